// File: rtl/finder_pattern_scanner_if.sv
// finder_pattern_scanner_if: scan control, frame BRAM read port and detection results
interface finder_pattern_scanner_if #(
  parameter int HEIGHT = 480,
  parameter int WIDTH  = 480
);
  logic              start_in;
  logic [19:0]       address_out;
  logic              pixel_in;
  logic [WIDTH-1:0]  horz_patterns;
  logic [HEIGHT-1:0] vert_patterns;
  logic              busy_out;
  logic              done_out;
  logic [15:0]       horz_hits_out;
  logic [15:0]       vert_hits_out;
  modport master (
    input  start_in, pixel_in,
    output address_out, horz_patterns, vert_patterns, busy_out, done_out, horz_hits_out, vert_hits_out
  );
  modport slave (
    output start_in, pixel_in,
    input  address_out, horz_patterns, vert_patterns, busy_out, done_out, horz_hits_out, vert_hits_out
  );
endinterface

// File: rtl/finder_pattern_scanner.sv
// finder_pattern_scanner: row then column scan of the frame BRAM, run-length 1:1:3:1:1 finder detection
module finder_pattern_scanner #(
  parameter int HEIGHT = 480,
  parameter int WIDTH  = 480
) (
  input logic clk_in,
  input logic rst_in,
  finder_pattern_scanner_if.master bus
);
  localparam int MX = WIDTH > HEIGHT ? WIDTH : HEIGHT;
  localparam int CW = $clog2(MX + 2);
  localparam int HI = $clog2(WIDTH);
  localparam int VI = $clog2(HEIGHT);
  localparam int TW = CW + 3;
  typedef enum logic [2:0] {IDLE, HSCAN, HDRAIN, VSCAN, VDRAIN, DONE} state_t;
  state_t state;
  logic [CW-1:0] pos, line, len, last_line, end_pos;
  logic [1:0] drain;
  logic [TW-1:0] t0, t1, t2;
  logic run_col, chk, chg, horz_phase, ratio_ok;
  logic [8:0] run_len, cur_len, w0, w1, w2, w3, w4;
  logic [2:0] runs, runs_base;
  logic signed [13:0] t;
  logic [13:0] center;
  logic [19:0] addr_next;
  function automatic logic near(input logic signed [13:0] d, input logic signed [13:0] tol);
    return (d[13] ? -d : d) <= tol;
  endfunction
  assign len = state == HSCAN ? CW'(WIDTH) : CW'(HEIGHT);
  assign last_line = state == HSCAN ? CW'(HEIGHT - 1) : CW'(WIDTH - 1);
  assign addr_next = state == HSCAN ? 20'(line) * 20'(WIDTH) + 20'(pos) : 20'(pos) * 20'(WIDTH) + 20'(line);
  assign chg = !t2[TW-2] && bus.pixel_in != run_col;
  assign cur_len = (t2[TW-2] || chg) ? 9'd1 : (&run_len ? run_len : run_len + 9'd1);
  assign runs_base = t2[TW-2] ? 3'd0 : runs;
  assign t = 14'(w0) + 14'(w1) + 14'(w2) + 14'(w3) + 14'(w4);
  assign ratio_ok = near(14'd7 * 14'(w0) - t, t >>> 1) && near(14'd7 * 14'(w1) - t, t >>> 1) &&
                    near(14'd7 * 14'(w3) - t, t >>> 1) && near(14'd7 * 14'(w4) - t, t >>> 1) &&
                    near(14'd7 * 14'(w2) - 14'd3 * t, t);
  assign center = 14'(end_pos) - 14'(w4) - 14'(w3) - 14'(w2) + 14'(w2 >> 1);
  assign horz_phase = state == HSCAN || state == HDRAIN;
  // sequencer issues addresses with tags; tagged pixels feed the run encoder; pushes of black runs are checked next cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      pos <= '0;
      line <= '0;
      drain <= '0;
      end_pos <= '0;
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
      run_col <= 1'b0;
      run_len <= '0;
      runs <= '0;
      chk <= 1'b0;
      {w0, w1, w2, w3, w4} <= '0;
      bus.address_out <= '0;
      bus.horz_patterns <= '0;
      bus.vert_patterns <= '0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.horz_hits_out <= '0;
      bus.vert_hits_out <= '0;
    end else begin
      bus.done_out <= 1'b0;
      t0 <= '0;
      t1 <= t0;
      t2 <= t1;
      chk <= 1'b0;
      case (state)
        IDLE: if (bus.start_in) begin
          state <= HSCAN;
          pos <= '0;
          line <= '0;
          bus.busy_out <= 1'b1;
          bus.horz_patterns <= '0;
          bus.vert_patterns <= '0;
          bus.horz_hits_out <= '0;
          bus.vert_hits_out <= '0;
        end
        HSCAN, VSCAN: if (pos != len) begin
          bus.address_out <= addr_next;
          t0 <= {1'b1, pos == '0, pos == len - 1'b1, pos};
          pos <= pos + 1'b1;
        end else begin
          pos <= '0;
          line <= line == last_line ? '0 : line + 1'b1;
          if (line == last_line) begin
            state <= state == HSCAN ? HDRAIN : VDRAIN;
            drain <= '0;
          end
        end
        HDRAIN, VDRAIN: begin
          drain <= drain + 1'b1;
          if (drain == 2'd2) state <= state == HDRAIN ? VSCAN : DONE;
        end
        default: begin
          bus.done_out <= 1'b1;
          bus.busy_out <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (t2[TW-1]) begin
        run_col <= bus.pixel_in;
        run_len <= cur_len;
        if (chg && t2[TW-3] && !bus.pixel_in) begin
          {w0, w1, w2, w3, w4} <= {w2, w3, w4, run_len, 9'd1};
          runs <= runs_base >= 3'd4 ? 3'd5 : runs_base + 3'd2;
          end_pos <= t2[CW-1:0] + 1'b1;
          chk <= 1'b1;
        end else if (chg || t2[TW-3]) begin
          {w0, w1, w2, w3, w4} <= {w1, w2, w3, w4, chg ? run_len : cur_len};
          runs <= runs_base == 3'd5 ? 3'd5 : runs_base + 3'd1;
          end_pos <= chg ? t2[CW-1:0] : t2[CW-1:0] + 1'b1;
          chk <= chg ? !run_col : !bus.pixel_in;
        end else runs <= runs_base;
      end
      if (chk && runs == 3'd5 && ratio_ok) begin
        if (horz_phase) begin
          if (center < 14'(WIDTH)) bus.horz_patterns[HI'(center)] <= 1'b1;
          if (!(&bus.horz_hits_out)) bus.horz_hits_out <= bus.horz_hits_out + 16'd1;
        end else begin
          if (center < 14'(HEIGHT)) bus.vert_patterns[VI'(center)] <= 1'b1;
          if (!(&bus.vert_hits_out)) bus.vert_hits_out <= bus.vert_hits_out + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_finder_pattern_scanner.sv
// tb_finder_pattern_scanner: directed and randomized frames checked against a whole-line run-length reference model
module tb_finder_pattern_scanner;
  localparam int H = 24, W = 32;
  localparam int DONE_AT = 1 + H * (W + 1) + 3 + W * (H + 1) + 3;
  logic clk = 1'b0, rst_n = 1'b0;
  bit frame [H][W];
  logic p1;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_h, got_h;
  logic [H-1:0] exp_v, got_v;
  int exp_hh, exp_vh, got_hh, got_vh, got_cyc, extra;
  bit busy_bad, busy_at_done;
  finder_pattern_scanner_if #(.HEIGHT(H), .WIDTH(W)) bus ();
  finder_pattern_scanner #(.HEIGHT(H), .WIDTH(W)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // frame memory with two cycles of read latency
  always @(posedge clk) begin
    p1 <= frame[int'(bus.address_out) / W][int'(bus.address_out) % W];
    bus.pixel_in <= p1;
  end
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  function automatic bit fits(input int a, input int b, input int c, input int d, input int e);
    int s = a + b + c + d + e;
    return iabs(7 * a - s) <= s / 2 && iabs(7 * b - s) <= s / 2 && iabs(7 * d - s) <= s / 2 &&
           iabs(7 * e - s) <= s / 2 && iabs(7 * c - 3 * s) <= s;
  endfunction
  // run-length encode each whole line, then test every five-run window that ends in a black run
  task automatic model();
    int rl[64];
    bit rc[64];
    int nr, e, c;
    exp_h = '0; exp_v = '0; exp_hh = 0; exp_vh = 0;
    for (int dir = 0; dir < 2; dir++)
      for (int ln = 0; ln < (dir ? W : H); ln++) begin
        nr = 0;
        for (int p = 0; p < (dir ? H : W); p++) begin
          bit px = dir ? frame[p][ln] : frame[ln][p];
          if (nr > 0 && rc[nr-1] == px) rl[nr-1]++;
          else begin rl[nr] = 1; rc[nr] = px; nr++; end
        end
        e = 0;
        for (int k = 0; k < nr; k++) begin
          e += rl[k];
          if (k >= 4 && !rc[k] && fits(rl[k-4], rl[k-3], rl[k-2], rl[k-1], rl[k])) begin
            c = e - rl[k] - rl[k-1] - rl[k-2] + rl[k-2] / 2;
            if (dir == 1) begin exp_v[c] = 1'b1; exp_vh++; end
            else begin exp_h[c] = 1'b1; exp_hh++; end
          end
        end
      end
  endtask
  task automatic clear_frame();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) frame[y][x] = 1'b1;
  endtask
  task automatic put_runs(input bit dir, input int ln, input int p0, input int a, input int b, input int c, input int d, input int e);
    int len[5];
    int p;
    len = '{a, b, c, d, e};
    p = p0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < len[k]; j++) begin
        if (dir) frame[p][ln] = k[0]; else frame[ln][p] = k[0];
        p++;
      end
  endtask
  task automatic random_frame();
    clear_frame();
    for (int i = 0; i < 30; i++) frame[$urandom_range(H-1)][$urandom_range(W-1)] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int m = $urandom_range(2, 1);
      int r[5];
      int tot = 0;
      bit dir = 1'($urandom_range(1));
      for (int k = 0; k < 5; k++) begin r[k] = m * (k == 2 ? 3 : 1) + $urandom_range(1); tot += r[k]; end
      put_runs(dir, $urandom_range(dir ? W - 1 : H - 1), $urandom_range((dir ? H : W) - tot), r[0], r[1], r[2], r[3], r[4]);
    end
  endtask
  // start a scan, optionally re-pulse start at cycle repulse, and capture the results at done
  task automatic run_scan(input int repulse);
    got_cyc = -1; busy_bad = 0; extra = 0; busy_at_done = 1;
    model();
    @(negedge clk) bus.start_in = 1'b1;
    @(negedge clk) bus.start_in = 1'b0;
    for (int k = 1; k <= DONE_AT + 50 && got_cyc < 0; k++) begin
      @(negedge clk);
      bus.start_in = (k == repulse);
      if (bus.done_out) begin got_cyc = k; busy_at_done = bus.busy_out; end
      else if (bus.busy_out !== 1'b1) busy_bad = 1;
    end
    bus.start_in = 1'b0;
    got_h = bus.horz_patterns; got_v = bus.vert_patterns;
    got_hh = int'(bus.horz_hits_out); got_vh = int'(bus.vert_hits_out);
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.done_out) extra++; end
  endtask
  task automatic test_reset();
    bus.start_in = 1'b0;
    #2;
    checks++; if (bus.address_out !== 20'd0) begin errors++; $display("FAIL reset address: got %h want 0", bus.address_out); end
    checks++; if (bus.horz_patterns !== '0 || bus.vert_patterns !== '0) begin errors++; $display("FAIL reset masks: got %h/%h want 0", bus.horz_patterns, bus.vert_patterns); end
    checks++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin errors++; $display("FAIL reset busy/done: got %b/%b want 0/0", bus.busy_out, bus.done_out); end
    checks++; if (bus.horz_hits_out !== 16'd0 || bus.vert_hits_out !== 16'd0) begin errors++; $display("FAIL reset hits: got %0d/%0d want 0/0", bus.horz_hits_out, bus.vert_hits_out); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL idle busy: got %b want 0", bus.busy_out); end
  endtask
  task automatic test_single_row();
    clear_frame();
    put_runs(0, 5, 2, 1, 1, 3, 1, 1);
    run_scan(0);
    checks++; if (got_cyc !== DONE_AT) begin errors++; $display("FAIL single_row done_cycle: got %0d want %0d", got_cyc, DONE_AT); end
    checks++; if (got_h !== exp_h || got_h !== 32'h20) begin errors++; $display("FAIL single_row horz: got %h want %h", got_h, exp_h); end
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL single_row vert: got %h want %h", got_v, exp_v); end
    checks++; if (got_hh !== 1 || got_vh !== exp_vh) begin errors++; $display("FAIL single_row hits: got %0d/%0d want 1/%0d", got_hh, got_vh, exp_vh); end
    checks++; if (busy_bad || busy_at_done !== 1'b0) begin errors++; $display("FAIL single_row busy: got bad=%0d at_done=%b want 0/0", busy_bad, busy_at_done); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL single_row extra_done: got %0d want 0", extra); end
  endtask
  task automatic test_scaled_finder();
    clear_frame();
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 14; j++) begin
        int m = i / 2;
        int n = j / 2;
        frame[10+i][10+j] = !(m == 0 || m == 6 || n == 0 || n == 6 || (m >= 2 && m <= 4 && n >= 2 && n <= 4));
      end
    run_scan(0);
    checks++; if (got_h !== exp_h || got_h !== (32'd1 << 17)) begin errors++; $display("FAIL finder horz: got %h want %h", got_h, exp_h); end
    checks++; if (got_v !== exp_v || got_v !== (24'd1 << 17)) begin errors++; $display("FAIL finder vert: got %h want %h", got_v, exp_v); end
    checks++; if (got_hh !== 6 || got_vh !== 6) begin errors++; $display("FAIL finder hits: got %0d/%0d want 6/6", got_hh, got_vh); end
    checks++; if (got_cyc !== DONE_AT) begin errors++; $display("FAIL finder done_cycle: got %0d want %0d", got_cyc, DONE_AT); end
  endtask
  task automatic test_tolerance();
    clear_frame();
    put_runs(0, 3, 4, 2, 2, 6, 2, 3);
    run_scan(0);
    checks++; if (got_h !== exp_h || got_h !== (32'd1 << 11)) begin errors++; $display("FAIL tol_accept horz: got %h want %h", got_h, exp_h); end
    checks++; if (got_hh !== 1) begin errors++; $display("FAIL tol_accept hits: got %0d want 1", got_hh); end
    clear_frame();
    put_runs(0, 3, 4, 2, 2, 6, 2, 4);
    run_scan(0);
    checks++; if (got_h !== exp_h || got_h !== '0) begin errors++; $display("FAIL tol_reject horz: got %h want 0", got_h); end
    checks++; if (got_hh !== 0 || got_vh !== 0) begin errors++; $display("FAIL tol_reject hits: got %0d/%0d want 0/0", got_hh, got_vh); end
  endtask
  task automatic test_edge();
    clear_frame();
    put_runs(0, 7, 25, 1, 1, 3, 1, 1);
    put_runs(1, 3, 17, 1, 1, 3, 1, 1);
    run_scan(0);
    checks++; if (got_h !== exp_h || !got_h[28]) begin errors++; $display("FAIL edge horz: got %h want %h", got_h, exp_h); end
    checks++; if (got_v !== exp_v || !got_v[20]) begin errors++; $display("FAIL edge vert: got %h want %h", got_v, exp_v); end
    checks++; if (got_hh !== exp_hh || got_vh !== exp_vh) begin errors++; $display("FAIL edge hits: got %0d/%0d want %0d/%0d", got_hh, got_vh, exp_hh, exp_vh); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    random_frame();
    @(negedge clk) bus.start_in = 1'b1;
    @(negedge clk) bus.start_in = 1'b0;
    repeat (900) @(negedge clk);
    checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL mid_reset busy_before: got %b want 1", bus.busy_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin errors++; $display("FAIL mid_reset busy/done: got %b/%b want 0/0", bus.busy_out, bus.done_out); end
    checks++; if (bus.horz_patterns !== '0 || bus.vert_patterns !== '0) begin errors++; $display("FAIL mid_reset masks: got %h/%h want 0", bus.horz_patterns, bus.vert_patterns); end
    checks++; if (bus.horz_hits_out !== 16'd0 || bus.vert_hits_out !== 16'd0 || bus.address_out !== 20'd0) begin errors++; $display("FAIL mid_reset hits/addr: got %0d/%0d/%h want 0", bus.horz_hits_out, bus.vert_hits_out, bus.address_out); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < DONE_AT; k++) begin @(negedge clk); if (bus.done_out || bus.busy_out) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset stray_activity: got %0d want 0", seen); end
    run_scan(0);
    checks++; if (got_cyc !== DONE_AT) begin errors++; $display("FAIL mid_reset rescan_cycle: got %0d want %0d", got_cyc, DONE_AT); end
    checks++; if (got_h !== exp_h || got_v !== exp_v) begin errors++; $display("FAIL mid_reset rescan_masks: got %h/%h want %h/%h", got_h, got_v, exp_h, exp_v); end
    checks++; if (got_hh !== exp_hh || got_vh !== exp_vh) begin errors++; $display("FAIL mid_reset rescan_hits: got %0d/%0d want %0d/%0d", got_hh, got_vh, exp_hh, exp_vh); end
  endtask
  task automatic test_restart_ignored();
    clear_frame();
    run_scan(100);
    checks++; if (got_cyc !== DONE_AT) begin errors++; $display("FAIL restart done_cycle: got %0d want %0d", got_cyc, DONE_AT); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL restart extra_done: got %0d want 0", extra); end
    checks++; if (got_h !== '0 || got_v !== '0) begin errors++; $display("FAIL restart masks: got %h/%h want 0", got_h, got_v); end
    checks++; if (got_hh !== 0 || got_vh !== 0) begin errors++; $display("FAIL restart hits: got %0d/%0d want 0/0", got_hh, got_vh); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      random_frame();
      run_scan(0);
      checks++; if (got_cyc !== DONE_AT) begin errors++; $display("FAIL random%0d done_cycle: got %0d want %0d", i, got_cyc, DONE_AT); end
      checks++; if (got_h !== exp_h) begin errors++; $display("FAIL random%0d horz: got %h want %h", i, got_h, exp_h); end
      checks++; if (got_v !== exp_v) begin errors++; $display("FAIL random%0d vert: got %h want %h", i, got_v, exp_v); end
      checks++; if (got_hh !== exp_hh || got_vh !== exp_vh) begin errors++; $display("FAIL random%0d hits: got %0d/%0d want %0d/%0d", i, got_hh, got_vh, exp_hh, exp_vh); end
    end
  endtask
  initial begin
    test_reset();
    test_single_row();
    test_scaled_finder();
    test_tolerance();
    test_edge();
    test_reset_mid();
    test_restart_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/finder_pattern_scanner.md
# finder_pattern_scanner

Upstream feeder of the cross-pattern center finder. It scans the binarized QR frame stored in the 1-bit frame BRAM, first row by row and then column by column. Each line is run-length encoded and tested for the 1:1:3:1:1 black/white finder signature. The block produces the `horz_patterns` / `vert_patterns` hit masks and a one-cycle `done_out` pulse, which drives `start_cross` of the downstream stage.

## Interface
- One clock; reset is asynchronous and active-low.
- Parameters:
  - `HEIGHT`, default 480: image rows.
  - `WIDTH`, default 480: image columns.
- Ports:
  - `clk_in`  in  1  system clock.
  - `rst_in`  in  1  asynchronous, active-low reset.
  - `start_in`  in  1  pulse; begin a scan of the frame currently in BRAM.
  - `address_out`  out  20  BRAM read address, `y*WIDTH + x`.
  - `pixel_in`  in  1  BRAM data, 1 = white, 0 = black. Valid exactly 2 cycles after the address is presented.
  - `horz_patterns`  out  WIDTH  bit x set if any row holds a signature centered at column x.
  - `vert_patterns`  out  HEIGHT  bit y set if any column holds a signature centered at row y.
  - `busy_out`  out  1  high from scan start until `done_out`.
  - `done_out`  out  1  one-cycle pulse; both masks are final on that cycle.
  - `horz_hits_out`  out  16  horizontal detections, saturating at 0xFFFF.
  - `vert_hits_out`  out  16  vertical detections, saturating at 0xFFFF.

## Operation
- **States:** IDLE, HSCAN, HDRAIN, VSCAN, VDRAIN, DONE.
- **IDLE:** on `start_in`, clear both masks and both hit counters, set `busy_out`, go to HSCAN. `start_in` in any other state is ignored.
- **HSCAN address issue:**
  - Rows y = 0..HEIGHT-1, x inner.
  - One address per cycle for WIDTH cycles, then one bubble cycle per line (no address). Line period is WIDTH+1 cycles.
  - After the last line go to HDRAIN.
- **Issue tags:** each issued address carries {valid, coord, line_first, line_last} through a 2-stage delay aligned with `pixel_in`.
- **HDRAIN:** 3 cycles, then VSCAN.
- **VSCAN:** identical to HSCAN with x outer and y inner; line length HEIGHT, period HEIGHT+1. Then VDRAIN (3 cycles), then DONE.
- **DONE:** pulse `done_out`, drop `busy_out`, return to IDLE. Masks and counters hold until the next start.
- **Run encoder (per tagged pixel):**
  - On `line_first`: start a new run (colour = pixel, length 1) and zero `runs_in_line`.
  - Same colour as the current run: length+1, saturating at 511.
  - Colour change: push the closed run and start a new run of length 1.
  - On `line_last`: also push the current run, including the final pixel.
- **Push operation:**
  - Shift window w0..w4 (w4 newest, 9 bits each).
  - Latch `end_pos` = coord of the first pixel after the run, i.e. the line length at a line end.
  - `runs_in_line` saturates at 5.
- **Check:** registered, one cycle after each push, on the updated window. It requires `runs_in_line` = 5 and the pushed run black, so the colours are B W B W B.
- **Check arithmetic** (14-bit signed, no truncation; T ≤ 2555):
  - T = w0+w1+w2+w3+w4.
  - For i ∈ {0,1,3,4}: |7·wi − T| ≤ T>>1.
  - |7·w2 − 3·T| ≤ T.
- **Hit handling:**
  - center = `end_pos` − w4 − w3 − w2 + (w2>>1).
  - Set the mask bit at center (horz in HSCAN/HDRAIN, vert in VSCAN/VDRAIN) and increment the corresponding hit counter.
  - Repeated hits on the same bit are legal; the counter still increments.

## Timing
- Reset values of all outputs are 0. State is IDLE and all internal registers are 0.
- Reset mid-scan: immediate return to IDLE with zeroed outputs and no `done_out`.
- Latency, with `start_in` sampled at cycle 0:
  - First address at cycle 1.
  - `done_out` at cycle 1 + HEIGHT·(WIDTH+1) + 3 + WIDTH·(HEIGHT+1) + 3.
- The bubble cycle guarantees the last check of a line precedes the next line's first pixel.
- Drain cycles guarantee the final check of each pass lands before the state changes.
- `address_out` holds its last value during bubbles, drain and IDLE; the value is don't-care.

## Test plan
- **Single-row hit:** WIDTH=HEIGHT=16, all white except row 5, x=2 B, x=3 W, x=4..6 B, x=7 W, x=8 B.
  - Required: `horz_patterns` = only bit 5, `vert_patterns` = 0, `horz_hits_out`=1.
  - Required: `done_out` at cycle 1+272+3+272+3 = 551.
- **Scaled finder:** 32×32, 7-module finder at scale 2 occupying (10..23, 10..23).
  - Required: `horz_patterns` bit 17 and `vert_patterns` bit 17 set, no others.
  - Required: each hit counter = 6, one per row/column crossing the 3-module core.
- **Tolerance:**
  - Row runs 2:2:6:2:3 (T=15) are accepted.
  - Row runs 2:2:6:2:4 (T=16, |28−16|=12 > 8) are rejected and leave the mask at 0.
- **Edge pattern:** signature whose last black run ends at x=WIDTH-1.
  - Required: detected via the `line_last` push; center bit set correctly.
- **Reset mid-VSCAN:** drive `rst_in` low.
  - Required: all outputs 0 on the same cycle, no `done_out`.
  - Required: a following `start_in` completes a full scan with correct masks.
- **All-white frame, plus `start_in` re-pulsed during HSCAN:**
  - Required: second pulse ignored, one `done_out` at the formula cycle, masks and counters 0.
